// File: rtl/mem_access_ctrl_if.sv
// Core-side request/response handshake for the load/store sequencer.
// master = core, slave = mem_access_ctrl.
interface mem_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic        req_wide;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_op, req_wide, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_wide, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store/push/pop sequencer in front of a 256x8 data memory.
// Splits byte/16-bit requests into single-byte memory cycles and owns the stack pointer.
module mem_access_ctrl #(
    parameter logic [7:0] SP_INIT    = 8'hFF,
    parameter logic [7:0] STACK_BASE = 8'h80
) (
    input  logic               clk,
    input  logic               reset_n,
    mem_access_ctrl_if.slave   bus,
    output logic [7:0]         sp_out,
    output logic [7:0]         mem_addr,
    output logic [7:0]         mem_din,
    output logic               mem_wr_en,
    input  logic [7:0]         mem_dout
);
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = AW + 1;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_PUSH  = 2'b10;
    localparam logic [1:0] OP_POP   = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_ACC0, S_ACC1, S_RESP} state_e;

    state_e          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic            wide_q, wide_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [AW-1:0]   sp_q, sp_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_err_q, rsp_err_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic [CW-1:0]   req_n;
    logic            push_ovf;
    logic            pop_unf;
    logic            is_write;
    logic            hi;
    logic [AW-1:0]   n_q;
    logic [AW-1:0]   acc_addr;
    logic [AW-1:0]   acc_din;

    // Stack bounds checked at accept with 9-bit arithmetic so nothing wraps.
    assign req_n    = bus.req_wide ? CW'(2) : CW'(1);
    assign push_ovf = {1'b0, sp_q} < (CW'(STACK_BASE) + req_n - CW'(1));
    assign pop_unf  = ({1'b0, sp_q} + req_n) > CW'(SP_INIT);

    assign is_write = (op_q == OP_STORE) || (op_q == OP_PUSH);
    assign hi       = (state_q == S_ACC1);
    assign n_q      = wide_q ? AW'(2) : AW'(1);

    // Byte lane mapping for the current access cycle; SP only moves after the last one.
    always_comb begin
        acc_addr = '0;
        acc_din  = '0;
        unique case (op_q)
            OP_LOAD, OP_STORE: begin
                acc_addr = hi ? addr_q + AW'(1) : addr_q;
                acc_din  = hi ? wdata_q[15:8] : wdata_q[7:0];
            end
            OP_PUSH: begin
                acc_addr = hi ? sp_q - AW'(1) : sp_q;
                acc_din  = (hi || !wide_q) ? wdata_q[7:0] : wdata_q[15:8];
            end
            OP_POP: begin
                acc_addr = hi ? sp_q + AW'(2) : sp_q + AW'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        wide_d      = wide_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        sp_d        = sp_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        mem_addr    = '0;
        mem_din     = '0;
        mem_wr_en   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    op_d    = bus.req_op;
                    wide_d  = bus.req_wide;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    rdata_d = '0;
                    if ((bus.req_op == OP_PUSH && push_ovf) ||
                        (bus.req_op == OP_POP && pop_unf)) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d = S_ACC0;
                    end
                end
            end
            S_ACC0, S_ACC1: begin
                mem_addr  = acc_addr;
                mem_din   = is_write ? acc_din : '0;
                mem_wr_en = is_write;
                if (!is_write) begin
                    if (hi) rdata_d[15:8] = mem_dout;
                    else    rdata_d[7:0]  = mem_dout;
                end
                if (hi || !wide_q) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = is_write ? '0 : rdata_d;
                    if (op_q == OP_PUSH)     sp_d = sp_q - n_q;
                    else if (op_q == OP_POP) sp_d = sp_q + n_q;
                end else begin
                    state_d = S_ACC1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_LOAD;
            wide_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            sp_q        <= SP_INIT;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            wide_q      <= wide_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            sp_q        <= sp_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign sp_out        = sp_q;
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Load/store sequencer directly upstream of the 256x8 data memory.
- Accepts byte or 16-bit LOAD/STORE/PUSH/POP requests from the core over a valid/ready handshake.
- Splits each request into one or two single-byte memory cycles and maintains the stack pointer.
- Returns a one-cycle response; it is the only driver of the data memory's address, write-data and write-enable inputs.

Parameters:
SP_INIT, 8'hFF, stack pointer reset value; also the top of the stack (SP points at the next free byte; the stack grows down).
STACK_BASE, 8'h80, lowest address the stack may occupy.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept; high only in IDLE
req_op  in  2  00 LOAD, 01 STORE, 10 PUSH, 11 POP
req_wide  in  1  1 = 16-bit access, 0 = byte
req_addr  in  8  LOAD/STORE base address; ignored for PUSH/POP
req_wdata  in  16  store/push data; byte access uses [7:0]
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  16  load/pop data, zero-extended for byte; 0 for STORE/PUSH and on error
rsp_err  out  1  stack overflow/underflow; valid with rsp_valid
sp_out  out  8  current stack pointer
mem_addr  out  8  to memory address
mem_din  out  8  to memory write data
mem_wr_en  out  1  to memory write enable
mem_dout  in  8  from memory; combinational read of mem_addr

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, SP=SP_INIT.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - mem_wr_en=0, mem_addr=0, mem_din=0.
- Reset mid-operation aborts the request; a wide store/push may leave byte 0 written. No response is issued.
- States: IDLE, ACC0, ACC1, RESP.
- IDLE:
  - req_ready=1; mem_wr_en=0, mem_addr=0.
  - On req_valid, latch op, wide, addr and wdata; n = wide ? 2 : 1.
  - Error check at accept:
    - PUSH overflows if SP < STACK_BASE+n-1.
    - POP underflows if SP+n > SP_INIT (9-bit compare).
  - On error: go to RESP with rsp_err=1; no memory cycles, SP unchanged.
  - Otherwise go to ACC0.
- Byte mapping, all address arithmetic mod 256:
  - LOAD/STORE: ACC0 at addr (data[7:0]), ACC1 at addr+1 (data[15:8]).
  - PUSH: ACC0 writes at SP (byte: data[7:0]; wide: data[15:8]); wide ACC1 writes data[7:0] at SP-1. SP -= n.
  - POP: ACC0 reads SP+1 into data[7:0]; wide ACC1 reads SP+2 into data[15:8]. SP += n.
- ACC0/ACC1:
  - mem_addr and mem_din are driven combinationally from the latched request and current SP.
  - mem_wr_en=1 only for STORE/PUSH.
  - Read byte is captured from mem_dout at the end of the cycle.
  - ACC0 goes to ACC1 if wide, else RESP; ACC1 goes to RESP.
  - SP updates at the clock edge ending the final access cycle, so sp_out is new in RESP.
- RESP: rsp_valid=1 for exactly one cycle with rsp_rdata and rsp_err; then IDLE. rsp_valid is 0 in all other states.
- Latency (accept edge to rsp_valid): byte 2 cycles, wide 3 cycles, error 1 cycle.
- Throughput: byte = one request per 3 cycles.
- req_valid held while req_ready=0 is ignored until IDLE. Requests never overlap.

Test Plan:
- Reset with req_valid=1 -> req_ready=1, sp_out=FF, mem_wr_en=0, rsp_valid=0.
- STORE wide addr=FF data=A55A, then LOAD wide addr=FF -> mem[FF]=5A, mem[00]=A5 (wrap); load rsp_rdata=A55A, rsp_valid 3 cycles after accept.
- PUSH wide 1234, PUSH byte 77, POP byte, POP wide:
  - mem[FF]=12, mem[FE]=34, mem[FD]=77.
  - SP: FD, FC, FD, FF.
  - POP byte returns 0077; POP wide returns 1234.
- POP byte at SP=FF -> rsp_err=1, rsp_rdata=0, SP stays FF, no memory access, rsp_valid 1 cycle after accept.
- Overflow: SP=80, PUSH wide -> rsp_err=1, SP=80, mem_wr_en never high. PUSH byte -> succeeds, mem[80] written, SP=7F. Next PUSH byte -> rsp_err=1.
- Assert reset_n low during ACC1 of a wide STORE -> immediate IDLE, SP=FF, no rsp_valid. Next request completes normally.
